cc_miss_req_unit: RTL and testbench

Miss-request issue stage of the cache controller, directly upstream of the data fill unit. It accepts cache-miss requests from the tag-compare logic and pushes each miss address into the miss address FIFO. The fill unit pops that FIFO when the line returns. It also issues one AXI read-address (AR) burst per miss: critical-word-first, 8 beats × 64 bits wrapping. It tracks outstanding line fills to bound the memory-side pipeline.

---
 rtl/cc_miss_req_unit.sv | 116 +++++++++++
 tb/tb_cc_miss_req_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_req_unit.sv
// Miss-request issue stage: pushes miss addresses to the fill FIFO and issues one
// wrapping 8x64-bit AXI AR burst per miss. Optional merging of same-line misses: CC_MISS_MERGE_EN.
module cc_miss_req_unit #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ready_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        fill_done_i,
    output logic [3:0]  outstanding_o,
    output logic        busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);

    state_t      state_q, state_d;
    logic [31:0] araddr_q;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        can_issue;
    logic        merge_hit;
    logic        accept;
    logic        push;
    logic        drain;

    assign can_issue = (state_q == IDLE) && !miss_addr_fifo_full_i && (outstanding_q < MaxCnt);

`ifdef CC_MISS_MERGE_EN
    logic [25:0] last_line_q;
    logic        last_valid_q;

    // A hit on the line already in flight is acknowledged regardless of FIFO/limit back-pressure.
    assign merge_hit = (state_q == IDLE) && last_valid_q && (outstanding_q != 4'd0)
                       && (miss_addr_i[31:6] == last_line_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_line_q  <= '0;
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_line_q  <= miss_addr_i[31:6];
            last_valid_q <= 1'b1;
        end else if (outstanding_d == 4'd0) begin
            last_valid_q <= 1'b0;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign miss_ready_o = can_issue || merge_hit;
    assign accept       = miss_i && miss_ready_o;
    assign push         = accept && !merge_hit;
    // A fill completion with nothing in flight is ignored so the count saturates at zero.
    assign drain        = fill_done_i && (outstanding_q != 4'd0);

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        outstanding_d = outstanding_q;
        if (push && !drain) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!push && drain) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push) state_d = REQ;
            REQ:  if (mem_arready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            araddr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            if (push) begin
                araddr_q <= {miss_addr_i[31:3], 3'b000};
            end
        end
    end

    assign miss_addr_fifo_wren_o  = push;
    assign miss_addr_fifo_wdata_o = miss_addr_i;
    assign mem_arvalid_o          = (state_q == REQ);
    assign mem_araddr_o           = araddr_q;
    assign mem_arlen_o            = 4'd7;
    assign mem_arsize_o           = 3'b011;
    assign mem_arburst_o          = 2'b10;
    assign outstanding_o          = outstanding_q;
    assign busy_o                 = (state_q != IDLE) || (outstanding_q != 4'd0);

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed, table-driven bench for cc_miss_req_unit (default MAX_OUTSTANDING = 4).
module tb_cc_miss_req_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        fifo_full;
    logic        fifo_wren;
    logic [31:0] fifo_wdata;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        fill_done;
    logic [3:0]  outstanding;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_miss_req_unit #(.MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_i                 (miss),
        .miss_addr_i            (miss_addr),
        .miss_ready_o           (miss_ready),
        .miss_addr_fifo_full_i  (fifo_full),
        .miss_addr_fifo_wren_o  (fifo_wren),
        .miss_addr_fifo_wdata_o (fifo_wdata),
        .mem_arvalid_o          (arvalid),
        .mem_arready_i          (arready),
        .mem_araddr_o           (araddr),
        .mem_arlen_o            (arlen),
        .mem_arsize_o           (arsize),
        .mem_arburst_o          (arburst),
        .fill_done_i            (fill_done),
        .outstanding_o          (outstanding),
        .busy_o                 (busy)
    );

    typedef struct {
        logic        miss;
        logic [31:0] addr;
        logic        full;
        logic        arready;
        logic        fill;
        logic        ready;
        logic        wren;
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  outs;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic m, logic [31:0] a, logic f, logic ar, logic fd,
                                logic rdy, logic wr, logic av, logic [31:0] ad,
                                logic [3:0] o, logic b);
        vec_t v;
        v.miss = m;   v.addr = a;     v.full = f;    v.arready = ar; v.fill = fd;
        v.ready = rdy; v.wren = wr;   v.arvalid = av; v.araddr = ad; v.outs = o; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_consts(input string tag);
        check({tag, " arlen"},   32'(arlen),   32'd7);
        check({tag, " arsize"},  32'(arsize),  32'd3);
        check({tag, " arburst"}, 32'(arburst), 32'd2);
    endtask

    // Drive at posedge+1, compare at the falling edge, then advance one clock.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag       = $sformatf("v%0d", idx);
        miss      = v.miss;
        miss_addr = v.addr;
        fifo_full = v.full;
        arready   = v.arready;
        fill_done = v.fill;
        #4;
        check({tag, " ready"},   32'(miss_ready),  32'(v.ready));
        check({tag, " wren"},    32'(fifo_wren),   32'(v.wren));
        if (v.wren) check({tag, " wdata"}, fifo_wdata, v.addr);
        check({tag, " arvalid"}, 32'(arvalid),     32'(v.arvalid));
        check({tag, " araddr"},  araddr,           v.araddr);
        check({tag, " outs"},    32'(outstanding), 32'(v.outs));
        check({tag, " busy"},    32'(busy),        32'(v.busy));
        check_consts(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //                miss addr          full ar fd  rdy wr av araddr         outs busy
        // single miss, arready high
        tbl.push_back(mk(1, 32'h0001_2468, 0, 1, 0,  1, 1, 0, 32'h0000_0000, 0, 0));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0001_2468, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0001_2468, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  1, 0, 0, 32'h0001_2468, 0, 0));
        // AR backpressure: arready low for 5 cycles, a new miss held throughout
        tbl.push_back(mk(1, 32'h0000_ABCD, 0, 0, 0,  1, 1, 0, 32'h0001_2468, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'h0000_3330, 0, 0, 0,  0, 0, 1, 32'h0000_ABC8, 1, 1));
        tbl.push_back(mk(1, 32'h0000_3330, 0, 1, 0,  0, 0, 1, 32'h0000_ABC8, 1, 1));
        tbl.push_back(mk(1, 32'h0000_3330, 0, 0, 0,  1, 1, 0, 32'h0000_ABC8, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_3330, 2, 1));
        // fill to the outstanding limit
        tbl.push_back(mk(1, 32'h0000_4008, 0, 1, 0,  1, 1, 0, 32'h0000_3330, 2, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_4008, 3, 1));
        tbl.push_back(mk(1, 32'h0000_5010, 0, 1, 0,  1, 1, 0, 32'h0000_4008, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_5010, 4, 1));
        tbl.push_back(mk(1, 32'h0000_6018, 0, 1, 0,  0, 0, 0, 32'h0000_5010, 4, 1));
        tbl.push_back(mk(1, 32'h0000_6018, 0, 1, 1,  0, 0, 0, 32'h0000_5010, 4, 1));
        tbl.push_back(mk(1, 32'h0000_6018, 0, 1, 0,  1, 1, 0, 32'h0000_5010, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  0, 0, 1, 32'h0000_6018, 4, 1));
        // accept and fill_done together: count unchanged
        tbl.push_back(mk(1, 32'h0000_7020, 0, 1, 1,  1, 1, 0, 32'h0000_6018, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_7020, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  1, 0, 0, 32'h0000_7020, 3, 1));
        // FIFO full blocks for 3 cycles, then same-cycle accept
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 32'h0000_8000, 1, 1, 0,  0, 0, 0, 32'h0000_7020, 3, 1));
        tbl.push_back(mk(1, 32'h0000_8000, 0, 0, 0,  1, 1, 0, 32'h0000_7020, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  0, 0, 1, 32'h0000_8000, 4, 1));
        // drain, including fill_done at zero
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  0, 0, 1, 32'h0000_8000, 4, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0000_8000, 3, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0000_8000, 2, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0000_8000, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0000_8000, 0, 0));
        tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  1, 0, 0, 32'h0000_8000, 0, 0));

        rst_n = 1'b0; miss = 1'b0; miss_addr = '0; fifo_full = 1'b0; arready = 1'b0; fill_done = 1'b0;
        #2;
        check("rst ready", 32'(miss_ready), 32'd1);
        check("rst wren", 32'(fifo_wren), 32'd0);
        check("rst arvalid", 32'(arvalid), 32'd0);
        check("rst araddr", araddr, 32'd0);
        check("rst outs", 32'(outstanding), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check_consts("rst");
        fifo_full = 1'b1;
        #1;
        check("rst ready full", 32'(miss_ready), 32'd0);
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset mid-operation with arvalid=1 and two fills in flight.
        apply(mk(1, 32'h0000_9000, 0, 1, 0,  1, 1, 0, 32'h0000_8000, 0, 0), 100);
        apply(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_9000, 1, 1), 101);
        apply(mk(1, 32'h0000_A000, 0, 0, 0,  1, 1, 0, 32'h0000_9000, 1, 1), 102);
        miss = 1'b0;
        check("pre-rst arvalid", 32'(arvalid), 32'd1);
        check("pre-rst outs", 32'(outstanding), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst arvalid", 32'(arvalid), 32'd0);
        check("async rst outs", 32'(outstanding), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst araddr", araddr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two misses to the same 64-byte line before any fill completes.
        apply(mk(1, 32'h0000_1040, 0, 1, 0,  1, 1, 0, 32'h0000_0000, 0, 0), 200);
        apply(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_1040, 1, 1), 201);
`ifdef CC_MISS_MERGE_EN
        apply(mk(1, 32'h0000_1078, 0, 1, 0,  1, 0, 0, 32'h0000_1040, 1, 1), 202);
        apply(mk(0, 32'h0000_0000, 0, 1, 0,  1, 0, 0, 32'h0000_1040, 1, 1), 203);
        // merge ignores FIFO full while the line is in flight
        apply(mk(1, 32'h0000_1050, 1, 1, 0,  1, 0, 0, 32'h0000_1040, 1, 1), 204);
        apply(mk(0, 32'h0000_0000, 0, 1, 1,  1, 0, 0, 32'h0000_1040, 1, 1), 205);
        // line invalidated once nothing is outstanding
        apply(mk(1, 32'h0000_1078, 1, 1, 0,  0, 0, 0, 32'h0000_1040, 0, 0), 206);
`else
        apply(mk(1, 32'h0000_1078, 0, 1, 0,  1, 1, 0, 32'h0000_1040, 1, 1), 202);
        apply(mk(0, 32'h0000_0000, 0, 1, 0,  0, 0, 1, 32'h0000_1078, 2, 1), 203);
        apply(mk(0, 32'h0000_0000, 0, 1, 0,  1, 0, 0, 32'h0000_1078, 2, 1), 204);
`endif
        v = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        miss = v.miss;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
